screen_scanner: RTL and testbench

- Read-side counterpart of the 8K x 16 screen memory.
- Walks the 512x256 Hack screen map (32 words per row, 256 rows; address = row*32 + col) in raster order, one word per read.
- Serialises each word into a 1-bit pixel stream over a valid/ready handshake, with start-of-frame, end-of-line and end-of-frame markers.
- Feeds a downstream video timing/encoder block; the CPU keeps writing the screen memory through its own port.

---
 rtl/screen_scanner_pkg.sv | 15 +
 rtl/screen_scanner_if.sv | 26 ++
 rtl/screen_scanner_word_serializer.sv | 56 +++++
 rtl/screen_scanner.sv | 129 ++++++++++++
 tb/tb_screen_scanner.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/screen_scanner_pkg.sv
// Shared constants and state type for the screen read-side scanner.
package screen_pkg;

    localparam int unsigned SCREEN_WORDS_PER_ROW = 32;
    localparam int unsigned SCREEN_ROWS          = 256;
    localparam int unsigned SCREEN_ADDR_W        = 13;
    localparam int unsigned PIX_PER_WORD         = 16;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM
    } scan_state_e;

endpackage

// File: rtl/screen_scanner_if.sv
// Screen memory read port plus the outgoing pixel stream with its markers.
interface screen_scanner_if
    import screen_pkg::*;
#(
    parameter int unsigned ADDR_W = SCREEN_ADDR_W
);
    logic                    rd_en;
    logic [ADDR_W-1:0]       rd_addr;
    logic [PIX_PER_WORD-1:0] rd_data;
    logic                    pix;
    logic                    pix_valid;
    logic                    pix_ready;
    logic                    sof;
    logic                    eol;
    logic                    eof;

    modport master (
        output rd_en, rd_addr, pix, pix_valid, sof, eol, eof,
        input  rd_data, pix_ready
    );

    modport slave (
        input  rd_en, rd_addr, pix, pix_valid, sof, eol, eof,
        output rd_data, pix_ready
    );
endinterface

// File: rtl/screen_scanner_word_serializer.sv
// Shift register emitting one word LSB-first, backed by a one-word holding register.
module word_serializer
    import screen_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    load,
    input  logic                    hold_wr,
    input  logic                    shift,
    input  logic [PIX_PER_WORD-1:0] din,
    output logic                    pix,
    output logic                    valid,
    output logic                    last,
    output logic                    hold_full
);
    localparam int unsigned BW = $clog2(PIX_PER_WORD);

    logic [PIX_PER_WORD-1:0] sh;
    logic [PIX_PER_WORD-1:0] hold;
    logic [BW-1:0]           bcnt;

    assign pix  = sh[0];
    assign last = (bcnt == BW'(PIX_PER_WORD - 1));

    // On acceptance of the final bit the held word drops straight in, so words abut.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            sh        <= '0;
            hold      <= '0;
            bcnt      <= '0;
            valid     <= 1'b0;
            hold_full <= 1'b0;
        end else begin
            if (load) begin
                sh    <= din;
                bcnt  <= '0;
                valid <= 1'b1;
            end else if (shift) begin
                if (last) begin
                    sh        <= hold;
                    valid     <= hold_full;
                    bcnt      <= '0;
                    hold_full <= 1'b0;
                end else begin
                    sh   <= sh >> 1;
                    bcnt <= bcnt + BW'(1);
                end
            end
            if (hold_wr) begin
                hold      <= din;
                hold_full <= 1'b1;
            end
        end
    end
endmodule

// File: rtl/screen_scanner.sv
// Raster-order reader of the screen memory producing a framed 1-bit pixel stream.
module screen_scanner
    import screen_pkg::*;
#(
    parameter int unsigned WORDS_PER_ROW = SCREEN_WORDS_PER_ROW,
    parameter int unsigned ROWS          = SCREEN_ROWS,
    parameter int unsigned ADDR_W        = SCREEN_ADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic             busy,
    screen_scanner_if.master bus
);
    localparam int unsigned XW = $clog2(WORDS_PER_ROW * PIX_PER_WORD);
    localparam int unsigned YW = $clog2(ROWS);
    localparam logic [XW-1:0] X_LAST = XW'(WORDS_PER_ROW * PIX_PER_WORD - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);

    scan_state_e       state;
    logic [XW-1:0]     x, x_n;
    logic [YW-1:0]     y, y_n;
    logic [ADDR_W-1:0] addr;
    logic              rd_pend;
    logic              sof_q, eol_q, eof_q;
    logic              rd_c, accept, at_eof, goto_idle;
    logic              ser_pix, ser_valid, ser_last, hold_full;

    word_serializer u_ser (
        .clk      (clk),
        .reset    (reset),
        .clear    (goto_idle),
        .load     (state == PRIME),
        .hold_wr  (rd_pend && (state == STREAM)),
        .shift    (accept),
        .din      (bus.rd_data),
        .pix      (ser_pix),
        .valid    (ser_valid),
        .last     (ser_last),
        .hold_full(hold_full)
    );

    assign bus.rd_en     = rd_c;
    assign bus.rd_addr   = addr;
    assign bus.pix       = ser_pix;
    assign bus.pix_valid = ser_valid;
    assign bus.sof       = sof_q;
    assign bus.eol       = eol_q;
    assign bus.eof       = eof_q;

    // Read issue, acceptance and next raster position.
    always_comb begin
        accept    = (state == STREAM) && ser_valid && bus.pix_ready;
        at_eof    = (x == X_LAST) && (y == Y_LAST);
        goto_idle = accept && at_eof && !(enable && hold_full);
        x_n       = (x == X_LAST) ? '0 : x + XW'(1);
        y_n       = y;
        if (x == X_LAST) begin
            y_n = (y == Y_LAST) ? '0 : y + YW'(1);
        end
        rd_c = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    rd_c = enable;
                // addr==0 while streaming means the next read is the following frame's first word
                STREAM:  rd_c = !hold_full && !rd_pend && !goto_idle && ((addr != '0) || enable);
                default: rd_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            rd_pend <= 1'b0;
            x       <= '0;
            y       <= '0;
            sof_q   <= 1'b0;
            eol_q   <= 1'b0;
            eof_q   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            rd_pend <= rd_c;
            if (rd_c) begin
                addr <= addr + ADDR_W'(1);
            end
            case (state)
                IDLE: begin
                    if (enable) begin
                        state <= PRIME;
                        busy  <= 1'b1;
                    end
                end
                PRIME: begin
                    state <= STREAM;
                    x     <= '0;
                    y     <= '0;
                    sof_q <= 1'b1;
                    eol_q <= 1'b0;
                    eof_q <= 1'b0;
                end
                STREAM: begin
                    if (goto_idle) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        addr  <= '0;
                        x     <= '0;
                        y     <= '0;
                        sof_q <= 1'b0;
                        eol_q <= 1'b0;
                        eof_q <= 1'b0;
                    end else if (accept) begin
                        x     <= x_n;
                        y     <= y_n;
                        sof_q <= (x_n == '0) && (y_n == '0);
                        eol_q <= (x_n == X_LAST);
                        eof_q <= (x_n == X_LAST) && (y_n == Y_LAST);
                    end
                end
                default: state <= IDLE;
            endcase
            // A mid-frame word boundary must always find the prefetched word waiting.
            if (accept && ser_last && !at_eof) begin
                assert (hold_full);
            end
        end
    end
endmodule

// File: tb/tb_screen_scanner.sv
// Directed bench for screen_scanner on a reduced 8-row screen with a 1-cycle-latency memory model.
module tb_screen_scanner;
    localparam int unsigned ROWS   = 8;
    localparam int unsigned AW     = 8;
    localparam int unsigned NWORDS = 256;
    localparam int unsigned FRAME  = NWORDS * 16;
    localparam int unsigned LOGN   = 8400;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic enable = 1'b0;
    logic busy;

    int checks = 0;
    int failures = 0;

    screen_scanner_if #(.ADDR_W(AW)) bus ();

    screen_scanner #(.WORDS_PER_ROW(32), .ROWS(ROWS), .ADDR_W(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .enable(enable),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [15:0]   mem [0:NWORDS-1];
    logic          pix_log [0:LOGN-1];
    logic          sof_log [0:LOGN-1];
    logic          eol_log [0:LOGN-1];
    logic          eof_log [0:LOGN-1];
    int            stamp   [0:LOGN-1];
    logic [AW-1:0] raddr_log [0:LOGN-1];
    int            acc = 0, rd_cnt = 0, cyc = 0, stab_viol = 0, out_viol = 0;
    logic          prev_stall = 1'b0;
    logic [4:0]    prev_vals = '0;

    always @(posedge clk) begin
        if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];
    end

    // Recorder: logs accepted pixels, reads, stall stability and buffer occupancy.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            if (bus.rd_en) begin
                if (rd_cnt < LOGN) raddr_log[rd_cnt] = bus.rd_addr;
                rd_cnt = rd_cnt + 1;
            end
            if (prev_stall && ({bus.pix_valid, bus.pix, bus.sof, bus.eol, bus.eof} !== prev_vals))
                stab_viol = stab_viol + 1;
            if (bus.pix_valid && bus.pix_ready) begin
                if (acc < LOGN) begin
                    pix_log[acc] = bus.pix;
                    sof_log[acc] = bus.sof;
                    eol_log[acc] = bus.eol;
                    eof_log[acc] = bus.eof;
                    stamp[acc]   = cyc;
                end
                acc = acc + 1;
            end
            if (rd_cnt - acc / 16 > 2) out_viol = out_viol + 1;
        end
        prev_stall = !reset && bus.pix_valid && !bus.pix_ready;
        prev_vals  = {bus.pix_valid, bus.pix, bus.sof, bus.eol, bus.eof};
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        acc = 0; rd_cnt = 0; stab_viol = 0; out_viol = 0;
    endtask

    task automatic run_until_acc(input int n, input int budget, input string name);
        int k;
        for (k = 0; k < budget && acc < n; k++) tick();
        if (acc < n) begin
            checks++; failures++;
            $display("FAIL %s_timeout: accepted %0d, required %0d", name, acc, n);
        end
    endtask

    function automatic logic [15:0] log_word(input int base);
        logic [15:0] w;
        for (int i = 0; i < 16; i++) w[i] = pix_log[base + i];
        return w;
    endfunction

    function automatic logic [14:0] outs();
        return {bus.rd_en, bus.rd_addr, bus.pix, bus.pix_valid, bus.sof, bus.eol, bus.eof, busy};
    endfunction

    function automatic int count_marks(input int which, input int n);
        int c = 0;
        for (int i = 0; i < n; i++)
            c += (which == 0) ? int'(sof_log[i]) : (which == 1) ? int'(eol_log[i]) : int'(eof_log[i]);
        return c;
    endfunction

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0; bus.pix_ready = 1'b0;
        repeat (3) tick();
        checks++;
        if (outs() !== '0) begin failures++; $display("FAIL reset_outputs: got %h, required 0", outs()); end
        reset = 1'b0;
        tick();
        checks++;
        if (outs() !== '0) begin failures++; $display("FAIL idle_outputs: got %h, required 0", outs()); end
    endtask

    task automatic test_first_word();
        clear_logs();
        enable = 1'b1; bus.pix_ready = 1'b1;
        #1;
        checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== '0) begin
            failures++; $display("FAIL c0_read: rd_en=%b rd_addr=%h, required 1/00", bus.rd_en, bus.rd_addr);
        end
        tick();
        checks++;
        if (bus.pix_valid !== 1'b0) begin failures++; $display("FAIL c1_no_valid: got %b, required 0", bus.pix_valid); end
        tick();
        checks++;
        if ({bus.pix_valid, bus.sof, bus.eol, bus.eof, bus.pix} !== 5'b11001) begin
            failures++;
            $display("FAIL c2_first_pixel: valid/sof/eol/eof/pix=%b%b%b%b%b, required 11001",
                     bus.pix_valid, bus.sof, bus.eol, bus.eof, bus.pix);
        end
        run_until_acc(20, 100, "first_word");
        checks++;
        if (log_word(0) !== 16'h0001) begin failures++; $display("FAIL first_word: got %h, required 0001", log_word(0)); end
        checks++;
        if (count_marks(0, 20) !== 1) begin failures++; $display("FAIL single_sof: got %0d, required 1", count_marks(0, 20)); end
    endtask

    task automatic test_row_boundary();
        run_until_acc(600, 1000, "row");
        checks++;
        if (log_word(336) !== 16'hFFFF || log_word(320) !== 16'h0000) begin
            failures++; $display("FAIL word_15: got %h/%h, required ffff/0000", log_word(336), log_word(320));
        end
        checks++;
        if (eol_log[511] !== 1'b1 || pix_log[511] !== 1'b1 || count_marks(1, 600) !== 1) begin
            failures++;
            $display("FAIL eol_x511: eol=%b pix=%b count=%0d, required 1/1/1", eol_log[511], pix_log[511], count_marks(1, 600));
        end
        checks++;
        if (raddr_log[31] !== 8'h1F || raddr_log[32] !== 8'h20) begin
            failures++; $display("FAIL row1_addr: got %h/%h, required 1f/20", raddr_log[31], raddr_log[32]);
        end
        checks++;
        if (sof_log[512] !== 1'b0 || eol_log[512] !== 1'b0) begin
            failures++; $display("FAIL row1_markers: sof=%b eol=%b, required 0/0", sof_log[512], eol_log[512]);
        end
    endtask

    task automatic test_stall();
        run_until_acc(1630, 2000, "pre_stall");
        for (int k = 0; k < 400 && acc < 1680; k++) begin
            bus.pix_ready = ~bus.pix_ready;
            tick();
        end
        bus.pix_ready = 1'b1;
        checks++;
        if (log_word(1648) !== 16'h1234) begin failures++; $display("FAIL stall_word: got %h, required 1234", log_word(1648)); end
        checks++;
        if (stamp[1663] - stamp[1648] !== 30) begin
            failures++; $display("FAIL stall_pace: got %0d cycles, required 30", stamp[1663] - stamp[1648]);
        end
        checks++;
        if (stab_viol !== 0) begin failures++; $display("FAIL stall_stable: got %0d changes, required 0", stab_viol); end
    endtask

    task automatic test_full_frame();
        bus.pix_ready = 1'b1;
        run_until_acc(FRAME + 20, 5000, "frame");
        checks++;
        if ({eof_log[FRAME-1], eol_log[FRAME-1], pix_log[FRAME-1], eof_log[FRAME-2]} !== 4'b1110) begin
            failures++;
            $display("FAIL eof_pixel: eof/eol/pix/prev_eof=%b%b%b%b, required 1110",
                     eof_log[FRAME-1], eol_log[FRAME-1], pix_log[FRAME-1], eof_log[FRAME-2]);
        end
        checks++;
        if (count_marks(2, FRAME + 20) !== 1 || count_marks(0, FRAME + 20) !== 2) begin
            failures++;
            $display("FAIL frame_markers: eof=%0d sof=%0d, required 1/2", count_marks(2, FRAME + 20), count_marks(0, FRAME + 20));
        end
        checks++;
        if (sof_log[FRAME] !== 1'b1 || pix_log[FRAME] !== 1'b1 || stamp[FRAME] - stamp[FRAME-1] !== 1) begin
            failures++;
            $display("FAIL frame_wrap: sof=%b pix=%b gap=%0d, required 1/1/1", sof_log[FRAME], pix_log[FRAME], stamp[FRAME] - stamp[FRAME-1]);
        end
        checks++;
        if (stamp[FRAME-1] - stamp[2000] !== FRAME - 1 - 2000) begin
            failures++; $display("FAIL no_bubbles: got %0d, required %0d", stamp[FRAME-1] - stamp[2000], FRAME - 1 - 2000);
        end
        checks++;
        if (raddr_log[NWORDS-1] !== 8'hFF || raddr_log[NWORDS] !== 8'h00) begin
            failures++; $display("FAIL addr_wrap: got %h/%h, required ff/00", raddr_log[NWORDS-1], raddr_log[NWORDS]);
        end
        checks++;
        if (out_viol !== 0) begin failures++; $display("FAIL outstanding: got %0d overruns, required 0", out_viol); end
    endtask

    task automatic test_enable_drop();
        run_until_acc(FRAME + 1000, 2000, "pre_drop");
        enable = 1'b0;
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL busy_mid: got %b, required 1", busy); end
        run_until_acc(2 * FRAME, 5000, "drop");
        checks++;
        if (busy !== 1'b0 || bus.pix_valid !== 1'b0) begin
            failures++; $display("FAIL busy_after_eof: busy=%b valid=%b, required 0/0", busy, bus.pix_valid);
        end
        checks++;
        if (eof_log[2*FRAME-1] !== 1'b1) begin failures++; $display("FAIL drop_eof: got %b, required 1", eof_log[2*FRAME-1]); end
        repeat (20) tick();
        checks++;
        if (rd_cnt !== 2 * NWORDS || acc !== 2 * FRAME) begin
            failures++; $display("FAIL drop_quiet: reads=%0d pixels=%0d, required %0d/%0d", rd_cnt, acc, 2 * NWORDS, 2 * FRAME);
        end
    endtask

    task automatic test_reset_mid();
        clear_logs();
        enable = 1'b1; bus.pix_ready = 1'b1;
        run_until_acc(40, 100, "pre_reset");
        bus.pix_ready = 1'b0;
        tick(); tick();
        checks++;
        if (bus.pix_valid !== 1'b1) begin failures++; $display("FAIL stalled_valid: got %b, required 1", bus.pix_valid); end
        enable = 1'b0; reset = 1'b1;
        tick();
        checks++;
        if (outs() !== '0) begin failures++; $display("FAIL mid_reset: got %h, required 0", outs()); end
        reset = 1'b0;
        tick();
        checks++;
        if (outs() !== '0) begin failures++; $display("FAIL post_reset_idle: got %h, required 0", outs()); end
        clear_logs();
        enable = 1'b1; bus.pix_ready = 1'b1;
        #1;
        checks++;
        if (bus.rd_en !== 1'b1 || bus.rd_addr !== '0) begin
            failures++; $display("FAIL restart_read: rd_en=%b rd_addr=%h, required 1/00", bus.rd_en, bus.rd_addr);
        end
        run_until_acc(20, 100, "restart");
        checks++;
        if (sof_log[0] !== 1'b1 || log_word(0) !== 16'h0001) begin
            failures++; $display("FAIL restart_sof: sof=%b word=%h, required 1/0001", sof_log[0], log_word(0));
        end
        enable = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = 16'h0000;
        mem[8'h00] = 16'h0001;
        mem[8'h15] = 16'hFFFF;
        mem[8'h1F] = 16'h8000;
        mem[8'h67] = 16'h1234;
        mem[8'hFF] = 16'h8000;
        bus.pix_ready = 1'b0;
        test_reset();
        test_first_word();
        test_row_boundary();
        test_stall();
        test_full_frame();
        test_enable_drop();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
